aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched_pkg.sv | 31 +++
 rtl/aes_key_round.sv | 24 ++
 rtl/aes_key_sched.sv | 66 ++++++
 tb/tb_aes_key_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_pkg.sv
// Shared AES-128 key-schedule types and constants: FSM states, round counts, Rcon and S-box.
// Pure constants and combinational helpers; no latency, no flow control.
package aes_key_sched_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_KEYS   = 11;

  // Padded to 16 entries so any 4-bit round value indexes safely; unused rounds yield zero.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: derives round key rnd from round key rnd-1.
// Purely combinational; no flow control.
module aes_key_round
  import aes_key_sched_pkg::*;
(
  input  logic [127:0] prevKey,
  input  logic [3:0]   rnd,
  output logic [127:0] nextKey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prevKey;

  assign t  = subWord({w3[23:0], w3[31:24]}) ^ {RCON[rnd], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key schedule: accepts a cipher key and fills an 11-entry round-key store, one key per cycle.
// Done 10 cycles after accept; key_ready is low while expanding, so offered keys are ignored then.
module aes_key_sched
  import aes_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         done
);

  state_t       state, stateNext;
  logic [3:0]   rnd;
  logic [3:0]   prevIdx;
  logic [127:0] keyStore [NUM_KEYS];
  logic [127:0] roundKey;
  logic         accept;

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);
  assign done      = (state == DONE);
  assign accept    = key_valid && key_ready;

  // rnd is 0 outside an expansion; clamp so the store read never goes out of range.
  assign prevIdx = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;

  aes_key_round uRound (
    .prevKey (keyStore[prevIdx]),
    .rnd     (rnd),
    .nextKey (roundKey)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (accept) stateNext = EXPAND;
      EXPAND:     if (rnd == 4'(NUM_ROUNDS)) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= 4'd0;
      for (int i = 0; i < NUM_KEYS; i++) keyStore[i] <= 128'h0;
    end else begin
      state <= stateNext;
      if (accept) begin
        keyStore[0] <= key_in;
        rnd         <= 4'd1;
      end else if (state == EXPAND) begin
        keyStore[rnd] <= roundKey;
        if (rnd != 4'(NUM_ROUNDS)) rnd <= rnd + 4'd1;
      end
    end
  end

  assign rd_key = (rd_idx <= 4'(NUM_ROUNDS)) ? keyStore[rd_idx] : 128'h0;

endmodule

// File: tb/tb_aes_key_sched.sv
// Randomized and directed bench for aes_key_sched against a GF(2^8)-derived key-expansion model.
module tb_aes_key_sched;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   rcon [11];
  logic [127:0] refKeys [11];

  aes_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic buildTables();
    logic [7:0] r = 8'h01;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon[i] = r;
      r = xtime(r);
    end
  endtask

  task automatic expandRef(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkFlags(input string tag, input logic eBusy, input logic eDone, input logic eReady);
    chk({tag, ".busy"}, {127'h0, busy}, {127'h0, eBusy});
    chk({tag, ".done"}, {127'h0, done}, {127'h0, eDone});
    chk({tag, ".key_ready"}, {127'h0, key_ready}, {127'h0, eReady});
  endtask

  // One read per cycle, sampled mid-cycle while the store is stable.
  task automatic chkStore(input string tag, input bit zeros);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s.rd%0d", tag, i), rd_key, (zeros || i > 10) ? 128'h0 : refKeys[i]);
    end
  endtask

  task automatic runExpand(input string tag, input logic [127:0] k, input bit junk);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    expandRef(k);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (junk) begin
        key_in    = '1;
        key_valid = 1'b1;
      end else begin
        key_valid = 1'b0;
      end
      chkFlags($sformatf("%s.cyc%0d", tag, c), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    key_valid = 1'b0;
    chkFlags({tag, ".end"}, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b1;
    key_in    = 128'h0123456789abcdef0123456789abcdef;
    rd_idx    = 4'd0;
    buildTables();

    // Reset held with a key offered: reset must win and leave an empty store.
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    chkFlags("reset", 1'b0, 1'b0, 1'b1);
    chkStore("reset", 1'b1);

    // FIPS-197 vector, with an all-ones key offered throughout expansion.
    runExpand("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    chkStore("fips", 1'b0);
    @(negedge clk); rd_idx = 4'd0;  #1; chk("fips.k0",  rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk); rd_idx = 4'd1;  #1; chk("fips.k1",  rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    @(negedge clk); rd_idx = 4'd2;  #1; chk("fips.k2",  rd_key, 128'hf2c295f27a96b9435935807a7359f67f);
    @(negedge clk); rd_idx = 4'd10; #1; chk("fips.k10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Restart from DONE with the all-zero key.
    runExpand("zero", 128'h0, 1'b0);
    @(negedge clk); rd_idx = 4'd1; #1; chk("zero.k1", rd_key, 128'h62636363626363636263636362636363);
    chkStore("zero", 1'b0);

    for (int n = 0; n < 6; n++) begin
      logic [127:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      runExpand($sformatf("rand%0d", n), k, n[0]);
      chkStore($sformatf("rand%0d", n), 1'b0);
    end

    // Reset in the fifth busy cycle aborts expansion and wipes the store.
    @(negedge clk);
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    chkFlags("abort.pre", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chkFlags("abort", 1'b0, 1'b0, 1'b1);
    chkStore("abort", 1'b1);
    chkFlags("abort.idle", 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
